// File: rtl/utf8_encode_sequencer.sv
// utf8_encode_sequencer
// Drives a hardware_utf8 transcoder through its active-low strobe interface:
// each accepted 32-bit code point is loaded MSB first over the 8-bit din path,
// the transcoder status is checked, and the encoded bytes are read back one
// per valid/ready handshake on the byte stream.
//
// Build option: define UTF8_ENC_REPLACE_EN to re-encode an erroring character
// once as U+FFFD (EF BF BD). Without it, erroring characters are dropped.
module utf8_encode_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        chk_range,
    input  logic [31:0] char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last,
    output logic        err_pulse,
    output logic        busy,
    output logic [7:0]  u_din,
    output logic        u_cbe,
    output logic        u_chk_range,
    output logic        u_cin_n,
    output logic        u_bout_n,
    output logic        u_rst_in_n,
    output logic        u_rst_out_n,
    output logic        u_cout_n,
    output logic        u_bin_n,
    input  logic [7:0]  u_dout,
    input  logic        u_bout_eof,
    input  logic        u_error
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CLR   = 4'd1;
    localparam logic [3:0] S_LOAD0 = 4'd2;
    localparam logic [3:0] S_LOAD1 = 4'd3;
    localparam logic [3:0] S_LOAD2 = 4'd4;
    localparam logic [3:0] S_LOAD3 = 4'd5;
    localparam logic [3:0] S_CHECK = 4'd6;
    localparam logic [3:0] S_READ  = 4'd7;
    localparam logic [3:0] S_OUT   = 4'd8;

    localparam logic [31:0] REPLACEMENT_CHAR = 32'h0000_FFFD;

    logic [3:0]  state_q, state_d;
    logic [31:0] cbuf_q, cbuf_d;
`ifdef UTF8_ENC_REPLACE_EN
    logic        repl_q, repl_d;
`endif

    // Next-state logic: sequence CLR -> LOAD0..3 -> CHECK -> (READ, OUT)*.
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cbuf_d  = cbuf_q;
`ifdef UTF8_ENC_REPLACE_EN
        repl_d  = repl_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (char_valid) begin
                    cbuf_d  = char_data;
`ifdef UTF8_ENC_REPLACE_EN
                    repl_d  = 1'b0;
`endif
                    state_d = S_CLR;
                end
            end
            S_CLR:   state_d = S_LOAD0;
            S_LOAD0: state_d = S_LOAD1;
            S_LOAD1: state_d = S_LOAD2;
            S_LOAD2: state_d = S_LOAD3;
            S_LOAD3: state_d = S_CHECK;
            S_CHECK: begin
                if (u_error) begin
`ifdef UTF8_ENC_REPLACE_EN
                    // One replacement pass only; U+FFFD itself never errors,
                    // but the repl flag guarantees termination regardless.
                    if (!repl_q) begin
                        cbuf_d  = REPLACEMENT_CHAR;
                        repl_d  = 1'b1;
                        state_d = S_CLR;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end else if (u_bout_eof) begin
                    // Zero-length encoding: nothing to read back.
                    state_d = S_IDLE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_OUT;
            S_OUT: begin
                if (byte_ready) begin
                    state_d = u_bout_eof ? S_IDLE : S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and character buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q <= S_IDLE;
            cbuf_q  <= '0;
`ifdef UTF8_ENC_REPLACE_EN
            repl_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cbuf_q  <= cbuf_d;
`ifdef UTF8_ENC_REPLACE_EN
            repl_q  <= repl_d;
`endif
        end
    end

    // Output decode; everything is forced to its idle value while rst is high.
    always_comb begin
        char_ready = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        err_pulse  = 1'b0;
        busy       = 1'b0;
        u_din      = 8'h00;
        u_cin_n    = 1'b1;
        u_bout_n   = 1'b1;
        u_rst_in_n = 1'b1;
        if (rst) begin
            // Hold the transcoder cleared for as long as we are in reset.
            u_rst_in_n = 1'b0;
        end else begin
            busy = (state_q != S_IDLE);
            case (state_q)
                S_IDLE:  char_ready = 1'b1;
                S_CLR:   u_rst_in_n = 1'b0;
                S_LOAD0: begin
                    u_cin_n = 1'b0;
                    u_din   = cbuf_q[31:24];
                end
                S_LOAD1: begin
                    u_cin_n = 1'b0;
                    u_din   = cbuf_q[23:16];
                end
                S_LOAD2: begin
                    u_cin_n = 1'b0;
                    u_din   = cbuf_q[15:8];
                end
                S_LOAD3: begin
                    u_cin_n = 1'b0;
                    u_din   = cbuf_q[7:0];
                end
                S_CHECK: err_pulse = u_error;
                S_READ:  u_bout_n = 1'b0;
                S_OUT: begin
                    // The transcoder holds dout/bout_eof until the next bout
                    // strobe, so these stay stable under back-pressure.
                    byte_valid = 1'b1;
                    byte_data  = u_dout;
                    byte_last  = u_bout_eof;
                end
                default: ;
            endcase
        end
    end

    // Static transcoder controls: big-endian input, output side never reset
    // or used for decode.
    assign u_cbe       = 1'b1;
    assign u_chk_range = chk_range;
    assign u_rst_out_n = 1'b1;
    assign u_cout_n    = 1'b1;
    assign u_bin_n     = 1'b1;

endmodule

// File: tb/tb_utf8_encode_sequencer.sv
// Testbench for utf8_encode_sequencer. Contains a behavioural model of the
// attached transcoder (shift-in loader, encoder, byte read pointer) and a
// table of directed code points with hand-computed expected UTF-8 bytes.
module tb_utf8_encode_sequencer;

`ifdef UTF8_ENC_REPLACE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        chk_range;
    logic [31:0] char_data;
    logic        char_valid;
    logic        char_ready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        err_pulse;
    logic        busy;
    logic [7:0]  u_din;
    logic        u_cbe, u_chk_range, u_cin_n, u_bout_n, u_rst_in_n;
    logic        u_rst_out_n, u_cout_n, u_bin_n;
    logic [7:0]  u_dout;
    logic        u_bout_eof;
    logic        u_error;

    always #5 clk = ~clk;

    utf8_encode_sequencer dut (
        .clk(clk), .rst(rst), .chk_range(chk_range),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .err_pulse(err_pulse), .busy(busy),
        .u_din(u_din), .u_cbe(u_cbe), .u_chk_range(u_chk_range),
        .u_cin_n(u_cin_n), .u_bout_n(u_bout_n), .u_rst_in_n(u_rst_in_n),
        .u_rst_out_n(u_rst_out_n), .u_cout_n(u_cout_n), .u_bin_n(u_bin_n),
        .u_dout(u_dout), .u_bout_eof(u_bout_eof), .u_error(u_error)
    );

    // ---------------- transcoder model ----------------
    logic [31:0] m_cp;
    int          m_ptr;
    int          m_n;

    function automatic int enc_len(input logic [31:0] cp, input logic chk);
        if (cp[31] || (chk && cp >= 32'h0011_0000)) return 0;
        if (cp < 32'h80)        return 1;
        if (cp < 32'h800)       return 2;
        if (cp < 32'h1_0000)    return 3;
        if (cp < 32'h20_0000)   return 4;
        if (cp < 32'h400_0000)  return 5;
        return 6;
    endfunction

    function automatic logic [7:0] enc_byte(input logic [31:0] cp, input int n, input int idx);
        logic [31:0] tmp;
        logic [7:0]  lead_prefix, lead_mask;
        tmp = cp >> (6 * (n - 1 - idx));
        case (n)
            1: begin lead_prefix = 8'h00; lead_mask = 8'h7F; end
            2: begin lead_prefix = 8'hC0; lead_mask = 8'h1F; end
            3: begin lead_prefix = 8'hE0; lead_mask = 8'h0F; end
            4: begin lead_prefix = 8'hF0; lead_mask = 8'h07; end
            5: begin lead_prefix = 8'hF8; lead_mask = 8'h03; end
            default: begin lead_prefix = 8'hFC; lead_mask = 8'h01; end
        endcase
        if (idx == 0) return lead_prefix | (tmp[7:0] & lead_mask);
        return 8'h80 | (tmp[7:0] & 8'h3F);
    endfunction

    always @(posedge clk) begin
        if (!u_rst_in_n) begin
            m_cp  <= '0;
            m_ptr <= 0;
        end else if (!u_cin_n) begin
            m_cp  <= u_cbe ? {m_cp[23:0], u_din} : {u_din, m_cp[31:8]};
        end else if (!u_bout_n) begin
            m_ptr <= m_ptr + 1;
        end
    end

    always_comb begin
        m_n        = enc_len(m_cp, u_chk_range);
        u_error    = (m_n == 0);
        u_bout_eof = (m_ptr >= m_n);
        u_dout     = 8'h00;
        if (m_ptr > 0 && m_ptr <= m_n) u_dout = enc_byte(m_cp, m_n, m_ptr - 1);
    end

    // ---------------- scoring ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] cp;
        logic        chk;
        int          bp;        // cycles of byte_ready=0 on the first byte
        int          exp_n;
        logic [31:0] exp_bytes; // right-justified, first byte most significant
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [31:0] cp, input logic chk, input int bp,
                       input int n, input logic [31:0] b, input logic err);
        vec_t v;
        v.name = name; v.cp = cp; v.chk = chk; v.bp = bp;
        v.exp_n = n; v.exp_bytes = b; v.exp_err = err;
        vecs.push_back(v);
    endtask

    // ---------------- per-character driver/collector ----------------
    logic [7:0] got_b[8];
    int got_n, n_last, last_idx, n_err, err_k, first_k, idle_k;
    logic k1_ready, k1_busy, stable_bad, strobe_bad, timed_out;

    task automatic run_char(input logic [31:0] cp, input logic chk, input int bp);
        int         k;
        int         held;
        logic [7:0] hold_d;
        logic       hold_l;
        got_n = 0; n_last = 0; last_idx = -1; n_err = 0; err_k = -1;
        first_k = -1; idle_k = -1; k1_ready = 1'b1; k1_busy = 1'b0;
        stable_bad = 1'b0; strobe_bad = 1'b0; timed_out = 1'b0;
        held = 0; hold_d = 8'h00; hold_l = 1'b0;
        @(negedge clk);
        char_data = cp; chk_range = chk; char_valid = 1'b1; byte_ready = 1'b1;
        k = 0;
        while (!char_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!char_ready) begin
            timed_out = 1'b1;
            char_valid = 1'b0;
            return;
        end
        // The character is accepted on the next rising edge (T); the k-th
        // negedge after this point lies in cycle T+k.
        for (k = 1; k <= 100; k++) begin
            @(negedge clk);
            char_valid = 1'b0;
            if (k == 1) begin
                k1_ready = char_ready;
                k1_busy  = busy;
            end
            if (err_pulse) begin
                n_err++;
                err_k = k;
            end
            if (k > 1 && char_ready) begin
                idle_k = k;
                break;
            end
            if (byte_valid) begin
                if (first_k < 0) first_k = k;
                if (got_n == 0 && held < bp) begin
                    if (held > 0 && (byte_data !== hold_d || byte_last !== hold_l)) stable_bad = 1'b1;
                    if (!u_cin_n || !u_bout_n || !u_rst_in_n) strobe_bad = 1'b1;
                    hold_d = byte_data;
                    hold_l = byte_last;
                    held++;
                    byte_ready = 1'b0;
                end else begin
                    if (held > 0 && got_n == 0 && (byte_data !== hold_d || byte_last !== hold_l))
                        stable_bad = 1'b1;
                    byte_ready = 1'b1;
                    if (got_n < 8) got_b[got_n] = byte_data;
                    if (byte_last) begin
                        n_last++;
                        last_idx = got_n;
                    end
                    got_n++;
                end
            end
        end
        if (idle_k < 0) timed_out = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int exp_first, exp_idle, nb, k;
        rst = 1'b1; chk_range = 1'b1; char_data = '0; char_valid = 1'b0; byte_ready = 1'b1;

        // Reset state, sampled while rst is still asserted.
        repeat (3) @(negedge clk);
        check("rst char_ready",  char_ready,  1'b0);
        check("rst byte_valid",  byte_valid,  1'b0);
        check("rst byte_last",   byte_last,   1'b0);
        check("rst err_pulse",   err_pulse,   1'b0);
        check("rst busy",        busy,        1'b0);
        check("rst u_din",       u_din,       8'h00);
        check("rst u_rst_in_n",  u_rst_in_n,  1'b0);
        check("rst u_cin_n",     u_cin_n,     1'b1);
        check("rst u_bout_n",    u_bout_n,    1'b1);
        check("rst u_rst_out_n", u_rst_out_n, 1'b1);
        check("rst u_cout_n",    u_cout_n,    1'b1);
        check("rst u_bin_n",     u_bin_n,     1'b1);
        check("rst u_cbe",       u_cbe,       1'b1);
        check("u_chk_range fwd", u_chk_range, 1'b1);
        rst = 1'b0;
        #1;
        check("first idle char_ready", char_ready, 1'b1);
        check("first idle u_rst_in_n", u_rst_in_n, 1'b1);

        add("U+0041",        32'h41,       1, 0, 1, 32'h41,       0);
        add("U+20AC",        32'h20AC,     1, 0, 3, 32'hE282AC,   0);
        add("U+1F600",       32'h1F600,    1, 0, 4, 32'hF09F9880, 0);
        add("U+007F",        32'h7F,       1, 0, 1, 32'h7F,       0);
        add("U+0080",        32'h80,       1, 0, 2, 32'hC280,     0);
        add("U+07FF",        32'h7FF,      1, 0, 2, 32'hDFBF,     0);
        add("U+0800",        32'h800,      1, 0, 3, 32'hE0A080,   0);
        add("U+FFFF",        32'hFFFF,     1, 0, 3, 32'hEFBFBF,   0);
        add("U+10FFFF chk",  32'h10FFFF,   1, 0, 4, 32'hF48FBFBF, 0);
        add("0x110000 chk",  32'h110000,   1, 0, REPL ? 3 : 0, 32'hEFBFBD, 1);
        add("0x110000 nchk", 32'h110000,   0, 0, 4, 32'hF4908080, 0);
        add("0x80000000",    32'h80000000, 1, 0, REPL ? 3 : 0, 32'hEFBFBD, 1);
        add("0x80000000 nc", 32'h80000000, 0, 0, REPL ? 3 : 0, 32'hEFBFBD, 1);
        add("U+00E9 bp",     32'hE9,       1, 5, 2, 32'hC3A9,     0);

        foreach (vecs[i]) begin
            run_char(vecs[i].cp, vecs[i].chk, vecs[i].bp);
            check({vecs[i].name, " timeout"}, timed_out, 1'b0);
            check({vecs[i].name, " char_ready T+1"}, k1_ready, 1'b0);
            check({vecs[i].name, " busy T+1"}, k1_busy, 1'b1);
            check({vecs[i].name, " byte count"}, got_n, vecs[i].exp_n);
            for (int j = 0; j < vecs[i].exp_n && j < got_n && j < 8; j++)
                check($sformatf("%s byte %0d", vecs[i].name, j), got_b[j],
                      vecs[i].exp_bytes[8 * (vecs[i].exp_n - 1 - j) +: 8]);
            check({vecs[i].name, " last count"}, n_last, (vecs[i].exp_n > 0) ? 1 : 0);
            check({vecs[i].name, " last index"}, last_idx, (vecs[i].exp_n > 0) ? vecs[i].exp_n - 1 : -1);
            check({vecs[i].name, " err pulses"}, n_err, vecs[i].exp_err ? 1 : 0);
            check({vecs[i].name, " err cycle"}, err_k, vecs[i].exp_err ? 6 : -1);
            if (vecs[i].exp_n == 0) begin
                exp_first = -1;
                exp_idle  = 7;
            end else begin
                exp_first = (vecs[i].exp_err ? 14 : 8) + vecs[i].bp;
                exp_first = exp_first - vecs[i].bp; // first byte_valid is unaffected by back-pressure
                exp_idle  = (vecs[i].exp_err ? 6 : 0) + 2 * vecs[i].exp_n + 7 + vecs[i].bp;
            end
            check({vecs[i].name, " first byte cycle"}, first_k, exp_first);
            check({vecs[i].name, " next ready cycle"}, idle_k, exp_idle);
            check({vecs[i].name, " stable under bp"}, stable_bad, 1'b0);
            check({vecs[i].name, " no strobe under bp"}, strobe_bad, 1'b0);
        end

        // Reset during the second byte of U+20AC.
        @(negedge clk);
        char_data = 32'h20AC; chk_range = 1'b1; char_valid = 1'b1; byte_ready = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        nb = 0;
        k = 0;
        while (k < 60) begin
            if (byte_valid) begin
                nb++;
                if (nb == 2) break;
            end
            @(negedge clk);
            k++;
        end
        check("mid-rst reached byte 2", nb, 2);
        check("mid-rst byte 2 value", byte_data, 8'h82);
        byte_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mid-rst u_rst_in_n during rst", u_rst_in_n, 1'b0);
        check("mid-rst char_ready during rst", char_ready, 1'b0);
        @(negedge clk);
        check("mid-rst byte_valid after", byte_valid, 1'b0);
        check("mid-rst byte_last after",  byte_last,  1'b0);
        check("mid-rst busy after",       busy,       1'b0);
        check("mid-rst u_din after",      u_din,      8'h00);
        check("mid-rst u_bout_n after",   u_bout_n,   1'b1);
        check("mid-rst u_rst_in_n held",  u_rst_in_n, 1'b0);
        rst = 1'b0;
        #1;
        check("mid-rst char_ready release", char_ready, 1'b1);
        run_char(32'h41, 1'b1, 0);
        check("post-rst timeout",    timed_out, 1'b0);
        check("post-rst byte count", got_n, 1);
        check("post-rst byte value", got_b[0], 8'h41);
        check("post-rst last count", n_last, 1);
        check("post-rst no error",   n_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
